// File: rtl/klein_pkg.sv
// klein_pkg: shared types, default round counts and the 8-step serial schedule for KLEIN controllers.
package klein_pkg;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINAL, S_DONE} state_t;
    typedef enum logic [1:0] {M64 = 2'b00, M80 = 2'b01, M96 = 2'b10, MRSV = 2'b11} mode_t;

    localparam int NR64_DEF = 12;
    localparam int NR80_DEF = 16;
    localparam int NR96_DEF = 20;

    localparam logic [3:0] SELS_TAB [0:7] = '{4'b0111, 4'b1011, 4'b1001, 4'b0000,
                                              4'b0111, 4'b0011, 4'b0001, 4'b0000};
    localparam logic [4:0] SELK_TAB [0:7] = '{5'b00000, 5'b01010, 5'b01011, 5'b01010,
                                              5'b01100, 5'b10100, 5'b01110, 5'b01110};

endpackage

// File: rtl/klein_sched_rom.sv
// klein_sched_rom: cnt-indexed lookup of {sels, selk}, forced to zero when not enabled.
module klein_sched_rom
    import klein_pkg::*;
(
    input  logic       en_i,
    input  logic [2:0] cnt_i,
    output logic [3:0] sels_o,
    output logic [4:0] selk_o
);

    assign sels_o = en_i ? SELS_TAB[cnt_i] : '0;
    assign selk_o = en_i ? SELK_TAB[cnt_i] : '0;

endmodule

// File: rtl/klein_serial_ctrl.sv
// klein_serial_ctrl: start/busy/done/ack sequencer for the serial 8-cycle-per-round KLEIN datapath.
// Supports KLEIN-64/80/96 via a mode latched at start; every output is a decode of registered state.
module klein_serial_ctrl
    import klein_pkg::*;
#(
    parameter int NR64 = NR64_DEF,
    parameter int NR80 = NR80_DEF,
    parameter int NR96 = NR96_DEF,
    parameter int RW   = 5
) (
    input  logic          ck,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic          abort,
    input  logic          ack,
    output logic          busy,
    output logic [RW-1:0] round,
    output logic          round0,
    output logic          round1,
    output logic          last,
    output logic [3:0]    sels,
    output logic [4:0]    selk,
    output logic          done,
    output logic          err
);

    state_t        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [RW-1:0] round_q, round_d;
    logic [RW-1:0] nr_q, nr_d;
    logic          err_q, err_d;
    logic [RW-1:0] nr_sel;

    assign nr_sel = (mode == M64) ? RW'(NR64) : (mode == M80) ? RW'(NR80) : RW'(NR96);

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            round_q <= '0;
            nr_q    <= RW'(NR96);
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            round_q <= round_d;
            nr_q    <= nr_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        round_d = round_q;
        nr_d    = nr_q;
        err_d   = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            round_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start && mode == MRSV) err_d = 1'b1;
                    else if (start) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                        round_d = '0;
                        nr_d    = nr_sel;
                    end
                end
                S_RUN: begin
                    cnt_d = cnt_q + 3'd1;
                    // round reaches nr exactly as the last round's 8th step retires
                    if (cnt_q == 3'd7) begin
                        round_d = round_q + RW'(1);
                        if (round_q == nr_q - RW'(1)) state_d = S_FINAL;
                    end
                end
                S_FINAL: state_d = S_DONE;
                S_DONE: begin
                    if (ack) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        round_d = '0;
                    end
                end
            endcase
        end
    end

    assign busy   = (state_q == S_RUN) || (state_q == S_FINAL);
    assign round  = round_q;
    assign round0 = (state_q == S_RUN) && (round_q == '0);
    assign round1 = (state_q == S_RUN) && (round_q == RW'(1));
    assign last   = (state_q == S_FINAL);
    assign done   = (state_q == S_DONE);
    assign err    = err_q;

    klein_sched_rom u_rom (
        .en_i   (state_q == S_RUN),
        .cnt_i  (cnt_q),
        .sels_o (sels),
        .selk_o (selk)
    );

endmodule
